// File: rtl/qpu_evt_timing_queue_if.sv
// QIU write-back handshake carrying timestamped events into the timing queue.
`timescale 1ns/1ps
interface qpu_evt_timing_queue_if #(
    parameter int EDATA_W  = 64,
    parameter int OPRAND_W = 10,
    parameter int TIME_W   = 32
);
    logic                evq_i_valid;
    logic                evq_i_ready;
    logic [EDATA_W-1:0]  evq_i_edata;
    logic [OPRAND_W-1:0] evq_i_oprand;
    logic [TIME_W-1:0]   evq_i_tdata;

    // Producer side (QIU or testbench)
    modport master (
        output evq_i_valid,
        output evq_i_edata,
        output evq_i_oprand,
        output evq_i_tdata,
        input  evq_i_ready
    );

    // Consumer side (timing queue)
    modport slave (
        input  evq_i_valid,
        input  evq_i_edata,
        input  evq_i_oprand,
        input  evq_i_tdata,
        output evq_i_ready
    );
endinterface

// File: rtl/qpu_evt_timing_queue.sv
// QPU event timing queue: buffers timestamped events in an in-order FIFO,
// runs the QPU timeline and releases the head event when its timestamp is
// reached, flagging events that were already overdue when they got there.
`timescale 1ns/1ps
module qpu_evt_timing_queue #(
    parameter int EDATA_W  = 64,
    parameter int OPRAND_W = 10,
    parameter int TIME_W   = 32,
    parameter int DEPTH    = 8,
    parameter int CNT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    qpu_evt_timing_queue_if.slave evq_i,
    input  logic                 time_en,
    input  logic                 time_clr,
    input  logic                 flush,
    input  logic                 late_clr,
    output logic                 evq_o_valid,
    output logic [EDATA_W-1:0]   evq_o_edata,
    output logic [OPRAND_W-1:0]  evq_o_oprand,
    output logic                 evq_o_late,
    output logic [TIME_W-1:0]    evq_timer,
    output logic [CNT_W-1:0]     evq_count,
    output logic                 evq_late_err
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty can be told apart
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [AW-1:0]        wr_idx;
    logic [AW-1:0]        rd_idx;

    logic [EDATA_W-1:0]   mem_edata  [DEPTH];
    logic [OPRAND_W-1:0]  mem_oprand [DEPTH];
    logic [TIME_W-1:0]    mem_tdata  [DEPTH];

    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 head_late;
    logic [TIME_W-1:0]    head_tdata;

    assign wr_idx     = wr_ptr[AW-1:0];
    assign rd_idx     = rd_ptr[AW-1:0];
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
    assign empty      = (wr_ptr == rd_ptr);

    // Full is judged on registered state only, so a same-cycle pop never frees a slot
    assign evq_i.evq_i_ready = ~full & ~flush;
    assign push       = evq_i.evq_i_valid & ~full & ~flush;

    // The head is compared against the timer value before this cycle's increment
    assign head_tdata = mem_tdata[rd_idx];
    assign head_late  = (head_tdata < evq_timer);
    assign pop        = ~empty & ~flush & (head_tdata <= evq_timer);

    assign evq_count  = CNT_W'(wr_ptr - rd_ptr);

    // Timeline counter: clear has priority, otherwise count while enabled (wraps naturally)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evq_timer <= '0;
        end else if (time_clr) begin
            evq_timer <= '0;
        end else if (time_en) begin
            evq_timer <= evq_timer + 1'b1;
        end
    end

    // FIFO pointers: flush discards everything queued, otherwise push and pop independently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Event storage; contents are only meaningful between the pointers, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            mem_edata[wr_idx]  <= evq_i.evq_i_edata;
            mem_oprand[wr_idx] <= evq_i.evq_i_oprand;
            mem_tdata[wr_idx]  <= evq_i.evq_i_tdata;
        end
    end

    // Issue register: one-cycle valid pulse, payload holds its last issued value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evq_o_valid  <= 1'b0;
            evq_o_edata  <= '0;
            evq_o_oprand <= '0;
            evq_o_late   <= 1'b0;
        end else begin
            evq_o_valid <= pop;
            if (pop) begin
                evq_o_edata  <= mem_edata[rd_idx];
                evq_o_oprand <= mem_oprand[rd_idx];
                evq_o_late   <= head_late;
            end
        end
    end

    // Sticky late flag: a late issue beats a simultaneous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evq_late_err <= 1'b0;
        end else if (pop && head_late) begin
            evq_late_err <= 1'b1;
        end else if (late_clr) begin
            evq_late_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_qpu_evt_timing_queue.sv
// Self-checking bench for qpu_evt_timing_queue: directed scenarios plus a
// randomized run checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_qpu_evt_timing_queue;

    localparam int EDATA_W  = 64;
    localparam int OPRAND_W = 10;
    localparam int TIME_W   = 12;
    localparam int DEPTH    = 8;
    localparam int CNT_W    = 4;
    localparam logic [TIME_W-1:0] TMAX = {TIME_W{1'b1}};

    typedef struct packed {
        logic [EDATA_W-1:0]  edata;
        logic [OPRAND_W-1:0] oprand;
        logic [TIME_W-1:0]   tdata;
    } ev_t;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                time_en;
    logic                time_clr;
    logic                flush;
    logic                late_clr;
    logic                evq_o_valid;
    logic [EDATA_W-1:0]  evq_o_edata;
    logic [OPRAND_W-1:0] evq_o_oprand;
    logic                evq_o_late;
    logic [TIME_W-1:0]   evq_timer;
    logic [CNT_W-1:0]    evq_count;
    logic                evq_late_err;

    int n_checks = 0;
    int n_fails  = 0;

    // Reference model state
    ev_t                 m_q[$];
    logic [TIME_W-1:0]   m_timer;
    logic                m_ovalid;
    logic [EDATA_W-1:0]  m_oedata;
    logic [OPRAND_W-1:0] m_ooprand;
    logic                m_olate;
    logic                m_lerr;

    qpu_evt_timing_queue_if #(.EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(TIME_W)) wb ();

    qpu_evt_timing_queue #(
        .EDATA_W(EDATA_W), .OPRAND_W(OPRAND_W), .TIME_W(TIME_W),
        .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .evq_i        (wb),
        .time_en      (time_en),
        .time_clr     (time_clr),
        .flush        (flush),
        .late_clr     (late_clr),
        .evq_o_valid  (evq_o_valid),
        .evq_o_edata  (evq_o_edata),
        .evq_o_oprand (evq_o_oprand),
        .evq_o_late   (evq_o_late),
        .evq_timer    (evq_timer),
        .evq_count    (evq_count),
        .evq_late_err (evq_late_err)
    );

    always #5 clk = ~clk;

    // Behavioural model: events wait in order and leave once the timeline reaches them
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_q.delete();
                m_timer   = '0;
                m_ovalid  = 1'b0;
                m_oedata  = '0;
                m_ooprand = '0;
                m_olate   = 1'b0;
                m_lerr    = 1'b0;
            end else begin
                bit   do_issue;
                bit   is_late;
                bit   do_accept;
                ev_t  e;
                do_issue  = (m_q.size() > 0) && !flush && (m_q[0].tdata <= m_timer);
                is_late   = do_issue && (m_q[0].tdata < m_timer);
                do_accept = wb.evq_i_valid && (m_q.size() < DEPTH) && !flush;
                m_ovalid  = do_issue;
                if (do_issue) begin
                    e         = m_q.pop_front();
                    m_oedata  = e.edata;
                    m_ooprand = e.oprand;
                    m_olate   = is_late;
                end
                if (is_late)       m_lerr = 1'b1;
                else if (late_clr) m_lerr = 1'b0;
                if (flush) m_q.delete();
                if (do_accept) begin
                    e.edata  = wb.evq_i_edata;
                    e.oprand = wb.evq_i_oprand;
                    e.tdata  = wb.evq_i_tdata;
                    m_q.push_back(e);
                end
                if (time_clr)     m_timer = '0;
                else if (time_en) m_timer = m_timer + 1'b1;
            end
        end
    end

    task automatic drive_idle();
        wb.evq_i_valid  = 1'b0;
        wb.evq_i_edata  = '0;
        wb.evq_i_oprand = '0;
        wb.evq_i_tdata  = '0;
        time_clr        = 1'b0;
        flush           = 1'b0;
        late_clr        = 1'b0;
    endtask

    task automatic drive_push(input logic [TIME_W-1:0] td, input logic [EDATA_W-1:0] ed,
                              input logic [OPRAND_W-1:0] op);
        wb.evq_i_valid  = 1'b1;
        wb.evq_i_edata  = ed;
        wb.evq_i_oprand = op;
        wb.evq_i_tdata  = td;
    endtask

    task automatic clear_timer();
        time_clr = 1'b1;
        @(negedge clk);
        time_clr = 1'b0;
    endtask

    task automatic wait_timer(input logic [TIME_W-1:0] v);
        bit ok = 0;
        for (int i = 0; i < 6000; i++) begin
            if (evq_timer == v) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL wait_timer: timer never reached %0d (now %0d)", v, evq_timer);
        end
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        time_en = 1'b0;
        drive_idle();
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (evq_o_valid !== 1'b0)  begin n_fails++; $display("[TB] FAIL reset_valid: got %b want 0", evq_o_valid); end
        n_checks++; if (evq_o_edata !== '0)    begin n_fails++; $display("[TB] FAIL reset_edata: got %h want 0", evq_o_edata); end
        n_checks++; if (evq_o_oprand !== '0)   begin n_fails++; $display("[TB] FAIL reset_oprand: got %h want 0", evq_o_oprand); end
        n_checks++; if (evq_o_late !== 1'b0)   begin n_fails++; $display("[TB] FAIL reset_late: got %b want 0", evq_o_late); end
        n_checks++; if (evq_timer !== '0)      begin n_fails++; $display("[TB] FAIL reset_timer: got %0d want 0", evq_timer); end
        n_checks++; if (evq_count !== '0)      begin n_fails++; $display("[TB] FAIL reset_count: got %0d want 0", evq_count); end
        n_checks++; if (evq_late_err !== 1'b0) begin n_fails++; $display("[TB] FAIL reset_late_err: got %b want 0", evq_late_err); end
        n_checks++; if (wb.evq_i_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL reset_ready: got %b want 1", wb.evq_i_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic_issue();
        int pulses = 0;
        logic [TIME_W-1:0]   p_timer = '0;
        logic [EDATA_W-1:0]  p_edata = '0;
        logic [OPRAND_W-1:0] p_oprand = '0;
        logic                p_late = 1'b1;
        time_en = 1'b1;
        wait_timer(2);
        drive_push(10, 64'hDEAD_BEEF_0123_4567, 10'h2A5);
        @(negedge clk);
        drive_idle();
        n_checks++; if (evq_count !== 4'd1) begin n_fails++; $display("[TB] FAIL basic_count_after_push: got %0d want 1", evq_count); end
        for (int i = 0; i < 30; i++) begin
            if (evq_o_valid === 1'b1) begin
                pulses++;
                p_timer  = evq_timer;
                p_edata  = evq_o_edata;
                p_oprand = evq_o_oprand;
                p_late   = evq_o_late;
            end
            @(negedge clk);
        end
        n_checks++; if (pulses != 1)                     begin n_fails++; $display("[TB] FAIL basic_pulses: got %0d want 1", pulses); end
        n_checks++; if (p_timer !== 12'd11)              begin n_fails++; $display("[TB] FAIL basic_pulse_time: timer %0d want 11", p_timer); end
        n_checks++; if (p_edata !== 64'hDEAD_BEEF_0123_4567) begin n_fails++; $display("[TB] FAIL basic_edata: got %h want deadbeef01234567", p_edata); end
        n_checks++; if (p_oprand !== 10'h2A5)            begin n_fails++; $display("[TB] FAIL basic_oprand: got %h want 2a5", p_oprand); end
        n_checks++; if (p_late !== 1'b0)                 begin n_fails++; $display("[TB] FAIL basic_late: got %b want 0", p_late); end
        n_checks++; if (evq_count !== 4'd0)              begin n_fails++; $display("[TB] FAIL basic_count_end: got %0d want 0", evq_count); end
    endtask

    task automatic test_full_backpressure();
        int issued = 0;
        time_en = 1'b0;
        clear_timer();
        for (int i = 0; i < DEPTH; i++) begin
            drive_push(100, 64'(i + 1), 10'(i + 1));
            @(negedge clk);
        end
        drive_push(100, 64'h9999, 10'h099);
        #1;
        n_checks++; if (evq_count !== 4'd8)      begin n_fails++; $display("[TB] FAIL full_count: got %0d want 8", evq_count); end
        n_checks++; if (wb.evq_i_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL full_ready: got %b want 0", wb.evq_i_ready); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (evq_o_valid === 1'b1) issued++;
        end
        n_checks++; if (evq_count !== 4'd8)      begin n_fails++; $display("[TB] FAIL full_hold_count: got %0d want 8", evq_count); end
        n_checks++; if (issued != 0)             begin n_fails++; $display("[TB] FAIL full_no_issue: got %0d issues want 0", issued); end
        flush = 1'b1;
        #1;
        n_checks++; if (wb.evq_i_ready !== 1'b0) begin n_fails++; $display("[TB] FAIL flush_ready: got %b want 0", wb.evq_i_ready); end
        @(negedge clk);
        drive_idle();
        #1;
        n_checks++; if (evq_count !== 4'd0)      begin n_fails++; $display("[TB] FAIL flush_count: got %0d want 0", evq_count); end
        n_checks++; if (wb.evq_i_ready !== 1'b1) begin n_fails++; $display("[TB] FAIL flush_ready_back: got %b want 1", wb.evq_i_ready); end
        n_checks++; if (evq_o_valid !== 1'b0)    begin n_fails++; $display("[TB] FAIL flush_no_issue: got %b want 0", evq_o_valid); end
    endtask

    task automatic test_same_timestamp();
        int pulses = 0;
        int idx[2] = '{0, 0};
        logic lt[2] = '{1'b1, 1'b0};
        logic lerr_at2 = 1'b0;
        bit seen = 0;
        time_en = 1'b0;
        clear_timer();
        drive_push(20, 64'hA1, 10'h001); @(negedge clk);
        drive_push(20, 64'hA2, 10'h002); @(negedge clk);
        drive_idle();
        time_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (evq_o_valid === 1'b1) begin
                if (pulses < 2) begin
                    idx[pulses] = i;
                    lt[pulses]  = evq_o_late;
                    if (pulses == 1) lerr_at2 = evq_late_err;
                end
                pulses++;
            end
            @(negedge clk);
        end
        n_checks++; if (pulses != 2)           begin n_fails++; $display("[TB] FAIL same_ts_pulses: got %0d want 2", pulses); end
        n_checks++; if (idx[1] != idx[0] + 1)  begin n_fails++; $display("[TB] FAIL same_ts_consecutive: cycles %0d,%0d", idx[0], idx[1]); end
        n_checks++; if (lt[0] !== 1'b0)        begin n_fails++; $display("[TB] FAIL same_ts_first_late: got %b want 0", lt[0]); end
        n_checks++; if (lt[1] !== 1'b1)        begin n_fails++; $display("[TB] FAIL same_ts_second_late: got %b want 1", lt[1]); end
        n_checks++; if (lerr_at2 !== 1'b1)     begin n_fails++; $display("[TB] FAIL same_ts_late_err: got %b want 1", lerr_at2); end
        late_clr = 1'b1; @(negedge clk); late_clr = 1'b0;
        n_checks++; if (evq_late_err !== 1'b0) begin n_fails++; $display("[TB] FAIL late_clr: got %b want 0", evq_late_err); end

        // Clear coinciding with a late issue: the set must win
        time_en = 1'b0;
        clear_timer();
        drive_push(20, 64'hB1, 10'h011); @(negedge clk);
        drive_push(20, 64'hB2, 10'h012); @(negedge clk);
        drive_idle();
        time_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (evq_o_valid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (!seen) begin n_fails++; $display("[TB] FAIL set_wins_first_pulse: no issue seen"); end
        late_clr = 1'b1; @(negedge clk); late_clr = 1'b0;
        n_checks++; if (evq_o_valid !== 1'b1 || evq_o_late !== 1'b1)
            begin n_fails++; $display("[TB] FAIL set_wins_issue: valid %b late %b want 1 1", evq_o_valid, evq_o_late); end
        n_checks++; if (evq_late_err !== 1'b1) begin n_fails++; $display("[TB] FAIL set_wins_flag: got %b want 1", evq_late_err); end
        late_clr = 1'b1; @(negedge clk); late_clr = 1'b0;
        n_checks++; if (evq_late_err !== 1'b0) begin n_fails++; $display("[TB] FAIL set_wins_clear_after: got %b want 0", evq_late_err); end
    endtask

    task automatic test_late_arrival();
        logic [TIME_W-1:0] start_t[3] = '{12'd50, 12'd50, 12'd48};
        logic [TIME_W-1:0] push_t[3]  = '{12'd50, 12'd49, 12'd50};
        int                exp_k[3]   = '{2, 2, 3};
        logic              exp_l[3]   = '{1'b1, 1'b1, 1'b0};
        for (int c = 0; c < 3; c++) begin
            int   pk = -1;
            logic pl = 1'bx;
            logic [EDATA_W-1:0] pe = '0;
            time_en = 1'b1;
            clear_timer();
            wait_timer(start_t[c]);
            drive_push(push_t[c], 64'(32'hC0DE_0000 + c), 10'(c + 5));
            @(negedge clk);
            drive_idle();
            for (int k = 1; k <= 10; k++) begin
                if (evq_o_valid === 1'b1 && pk < 0) begin
                    pk = k;
                    pl = evq_o_late;
                    pe = evq_o_edata;
                end
                @(negedge clk);
            end
            n_checks++; if (pk != exp_k[c])  begin n_fails++; $display("[TB] FAIL late_arrival_%0d_cycle: got %0d want %0d", c, pk, exp_k[c]); end
            n_checks++; if (pl !== exp_l[c]) begin n_fails++; $display("[TB] FAIL late_arrival_%0d_late: got %b want %b", c, pl, exp_l[c]); end
            n_checks++; if (pe !== 64'(32'hC0DE_0000 + c)) begin n_fails++; $display("[TB] FAIL late_arrival_%0d_edata: got %h", c, pe); end
        end
        late_clr = 1'b1; @(negedge clk); late_clr = 1'b0;
    endtask

    task automatic test_clear_wrap();
        time_en = 1'b1;
        repeat (5) @(negedge clk);
        clear_timer();
        n_checks++; if (evq_timer !== '0)  begin n_fails++; $display("[TB] FAIL clr_with_en: got %0d want 0", evq_timer); end
        repeat (int'(TMAX)) @(negedge clk);
        n_checks++; if (evq_timer !== TMAX) begin n_fails++; $display("[TB] FAIL wrap_max: got %0d want %0d", evq_timer, TMAX); end
        @(negedge clk);
        n_checks++; if (evq_timer !== '0)  begin n_fails++; $display("[TB] FAIL wrap_zero: got %0d want 0", evq_timer); end
    endtask

    task automatic test_reset_mid();
        bit seen = 0;
        int stale = 0;
        time_en = 1'b0;
        clear_timer();
        drive_push(10,  64'hE0, 10'h0E0); @(negedge clk);
        drive_push(200, 64'hE1, 10'h0E1); @(negedge clk);
        drive_push(200, 64'hE2, 10'h0E2); @(negedge clk);
        drive_push(200, 64'hE3, 10'h0E3); @(negedge clk);
        drive_idle();
        n_checks++; if (evq_count !== 4'd4) begin n_fails++; $display("[TB] FAIL mid_count_before: got %0d want 4", evq_count); end
        time_en = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (evq_o_valid === 1'b1) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        n_checks++; if (!seen || evq_count !== 4'd3)
            begin n_fails++; $display("[TB] FAIL mid_pulse_with_3: seen %0d count %0d want 1 3", seen, evq_count); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (evq_o_valid !== 1'b0)  begin n_fails++; $display("[TB] FAIL mid_reset_valid: got %b want 0", evq_o_valid); end
        n_checks++; if (evq_o_edata !== '0 || evq_o_oprand !== '0 || evq_o_late !== 1'b0)
            begin n_fails++; $display("[TB] FAIL mid_reset_payload: edata %h oprand %h late %b want 0", evq_o_edata, evq_o_oprand, evq_o_late); end
        n_checks++; if (evq_count !== '0 || evq_timer !== '0 || evq_late_err !== 1'b0)
            begin n_fails++; $display("[TB] FAIL mid_reset_state: count %0d timer %0d lerr %b want 0", evq_count, evq_timer, evq_late_err); end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (evq_o_valid === 1'b1) stale++;
        end
        n_checks++; if (stale != 0) begin n_fails++; $display("[TB] FAIL mid_no_stale: got %0d issues want 0", stale); end
        n_checks++; if (evq_count !== '0) begin n_fails++; $display("[TB] FAIL mid_count_after: got %0d want 0", evq_count); end
    endtask

    task automatic test_random();
        int bad = 0;
        for (int i = 0; i < 800; i++) begin
            logic [TIME_W-1:0] td;
            if (m_timer >= 4) td = m_timer - 12'd4 + TIME_W'($urandom_range(0, 14));
            else              td = m_timer + TIME_W'($urandom_range(0, 10));
            if ($urandom_range(0, 1) == 1) drive_push(td, {$urandom, $urandom}, 10'($urandom));
            else                           wb.evq_i_valid = 1'b0;
            time_en  = ($urandom_range(0, 7) != 0);
            flush    = ($urandom_range(0, 39) == 0);
            late_clr = ($urandom_range(0, 9) == 0);
            time_clr = 1'b0;
            #1;
            n_checks++;
            if (evq_o_valid !== m_ovalid || evq_timer !== m_timer || evq_count !== CNT_W'(m_q.size()) ||
                evq_late_err !== m_lerr || wb.evq_i_ready !== ((m_q.size() < DEPTH) && !flush) ||
                (m_ovalid && (evq_o_edata !== m_oedata || evq_o_oprand !== m_ooprand || evq_o_late !== m_olate))) begin
                n_fails++;
                if (bad < 10)
                    $display("[TB] FAIL random_cycle_%0d: got v%b t%0d c%0d e%b r%b d%h o%h l%b want v%b t%0d c%0d e%b d%h o%h l%b",
                             i, evq_o_valid, evq_timer, evq_count, evq_late_err, wb.evq_i_ready, evq_o_edata,
                             evq_o_oprand, evq_o_late, m_ovalid, m_timer, m_q.size(), m_lerr, m_oedata, m_ooprand, m_olate);
                bad++;
            end
            @(negedge clk);
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_basic_issue();
        test_full_backpressure();
        test_same_timestamp();
        test_late_arrival();
        test_clear_wrap();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

endmodule
